// File: rtl/rs_pkg.sv
// Shared reservation-station types: allocator FSM states and default entry count.
// Latency: n/a (types only). Backpressure: n/a.
package rs_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } rs_state_e;

  localparam int RS_DEFAULT_ENTRIES = 4;

endpackage

// File: rtl/priority_select.sv
// Lowest-index selector: one-hot pick of the first valid resource, gated by allocate_i.
// Latency: combinational. Backpressure: grant_o=0 when nothing is valid or no request.
module priority_select #(
  parameter int N = 4
) (
  input  logic         allocate_i,
  input  logic [N-1:0] resource_valid_i,
  output logic         grant_o,
  output logic [N-1:0] select_o
);

  logic [N-1:0] cand;
  logic         found;

  always_comb begin
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (resource_valid_i[i] && !found) begin
        cand[i] = 1'b1;
        found   = 1'b1;
      end
    end
    grant_o  = allocate_i & found;
    select_o = grant_o ? cand : '0;
  end

endmodule

// File: rtl/rs_alloc_ctrl.sv
// Reservation-station entry allocator: lowest free entry granted, releases and flush free entries.
// Latency: grant same cycle, busy/count update next edge. Backpressure: no grant while full, flushing or in reset.
// Option: RS_ALLOC_BYPASS_EN lets entries released this cycle be re-granted in the same cycle.
module rs_alloc_ctrl
  import rs_pkg::*;
#(
  parameter int NUM_ENTRIES = RS_DEFAULT_ENTRIES,
  localparam int CW = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   alloc_req_i,
  output logic                   alloc_gnt_o,
  output logic [NUM_ENTRIES-1:0] alloc_entry_o,
  input  logic [NUM_ENTRIES-1:0] release_i,
  input  logic                   flush_i,
  output logic [NUM_ENTRIES-1:0] entry_busy_o,
  output logic [CW-1:0]          free_cnt_o,
  output logic                   full_o,
  output logic                   empty_o
);

  rs_state_e              state_q;
  logic [NUM_ENTRIES-1:0] busy_q;
  logic [CW-1:0]          free_cnt_q;
  logic [NUM_ENTRIES-1:0] valid_rel;
  logic [NUM_ENTRIES-1:0] avail;
  logic [CW-1:0]          rel_cnt;
  logic                   req_qual;

  // Releases of already-free entries are dropped so they never inflate the count.
  assign valid_rel = release_i & busy_q;

`ifdef RS_ALLOC_BYPASS_EN
  assign avail = ~busy_q | valid_rel;
`else
  assign avail = ~busy_q;
`endif

  assign req_qual = alloc_req_i & ~rst_i & ~flush_i & (state_q == ST_RUN);

  priority_select #(.N(NUM_ENTRIES)) u_sel (
    .allocate_i       (req_qual),
    .resource_valid_i (avail),
    .grant_o          (alloc_gnt_o),
    .select_o         (alloc_entry_o)
  );

  always_comb begin
    rel_cnt = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      rel_cnt = rel_cnt + CW'(valid_rel[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_RUN;
      busy_q     <= '0;
      free_cnt_q <= CW'(NUM_ENTRIES);
    end else if (flush_i) begin
      // Flush wins over any same-cycle release or allocate.
      state_q    <= ST_FLUSH;
      busy_q     <= '0;
      free_cnt_q <= CW'(NUM_ENTRIES);
    end else begin
      state_q    <= ST_RUN;
      // A bypass re-grant clears and sets the same bit, so it stays busy and the count nets to zero.
      busy_q     <= (busy_q & ~valid_rel) | alloc_entry_o;
      free_cnt_q <= free_cnt_q + rel_cnt - CW'(alloc_gnt_o);
    end
  end

  assign entry_busy_o = busy_q;
  assign free_cnt_o   = free_cnt_q;
  assign full_o       = (free_cnt_q == '0);
  assign empty_o      = (free_cnt_q == CW'(NUM_ENTRIES));

endmodule
